cpu_sequencer: RTL and testbench

Multi-cycle instruction sequencer for the RISC-V core. It steps each instruction through FETCH/DECODE/EXEC/MEM/WB and handshakes with instruction and data memory. It supplies the `ban` input of the control-signal decoder and gates its `RegWr`/`MemWr` into single-cycle commit strobes. It also traps on illegal encodings and counts retired instructions.

---
 rtl/cpu_sequencer.sv | 118 +++++++++++
 tb/tb_cpu_sequencer.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/cpu_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer with illegal-encoding trap and retire counter.
// Optional memory-request watchdog enabled by defining SEQ_MEM_TIMEOUT_EN.
module cpu_sequencer #(
   parameter int TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        run,
   input  logic        imem_ack,
   input  logic        dmem_ack,
   input  logic [4:0]  op,
   input  logic [2:0]  func3,
   output logic        imem_req,
   output logic        dmem_req,
   output logic        ir_we,
   output logic        pc_we,
   output logic        rf_we_en,
   output logic        mem_we_en,
   output logic        ban,
   output logic [2:0]  state,
   output logic        trap,
   output logic [31:0] retired
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_MEM    = 3'd4,
      S_WB     = 3'd5,
      S_UNUSED = 3'd6,
      S_TRAP   = 3'd7
   } state_t;

   localparam logic [4:0] OP_LOAD   = 5'b00000;
   localparam logic [4:0] OP_STORE  = 5'b01000;
   localparam logic [4:0] OP_BRANCH = 5'b11000;

   state_t cur;

   function automatic logic is_legal(input logic [4:0] o, input logic [2:0] f);
      case (o)
         5'b01101, 5'b00101, 5'b00100, 5'b01100, 5'b11011, 5'b11001: return 1'b1;
         OP_BRANCH: return !(f == 3'b010 || f == 3'b011);
         OP_LOAD:   return !(f == 3'b011 || f == 3'b110 || f == 3'b111);
         OP_STORE:  return f < 3'b011;
         default:   return 1'b0;
      endcase
   endfunction

   logic is_mem;
   assign is_mem = (op == OP_LOAD) || (op == OP_STORE);

`ifdef SEQ_MEM_TIMEOUT_EN
   logic [7:0] wcnt;
   logic       expired;
   assign expired = (wcnt == 8'(TIMEOUT - 1));
`else
   // The watchdog limit only matters when the timeout build is selected.
   logic unused_timeout;
   assign unused_timeout = ^TIMEOUT;
`endif

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cur     <= S_IDLE;
         retired <= '0;
`ifdef SEQ_MEM_TIMEOUT_EN
         wcnt    <= '0;
`endif
      end else begin
         case (cur)
            S_IDLE:   if (run) cur <= S_FETCH;
            S_FETCH: begin
               if (imem_ack) cur <= S_DECODE;
`ifdef SEQ_MEM_TIMEOUT_EN
               else if (expired) cur <= S_TRAP;
`endif
            end
            S_DECODE: cur <= is_legal(op, func3) ? S_EXEC : S_TRAP;
            S_EXEC:   cur <= is_mem ? S_MEM : S_WB;
            S_MEM: begin
               if (dmem_ack) cur <= S_WB;
`ifdef SEQ_MEM_TIMEOUT_EN
               else if (expired) cur <= S_TRAP;
`endif
            end
            S_WB: begin
               cur     <= run ? S_FETCH : S_IDLE;
               retired <= retired + 32'd1;
            end
            S_TRAP:   cur <= S_TRAP;
            default:  cur <= S_IDLE;
         endcase
`ifdef SEQ_MEM_TIMEOUT_EN
         // Any cycle that is not an unacknowledged wait leaves the counter at zero for the next entry.
         if ((cur == S_FETCH && !imem_ack) || (cur == S_MEM && !dmem_ack))
            wcnt <= wcnt + 8'd1;
         else
            wcnt <= '0;
`endif
      end
   end

   // Outputs decode straight from the state register, so reset drops requests immediately.
   assign state     = cur;
   assign imem_req  = (cur == S_FETCH);
   assign ir_we     = (cur == S_FETCH) && imem_ack;
   assign dmem_req  = (cur == S_MEM);
   assign mem_we_en = (cur == S_MEM) && (op == OP_STORE);
   assign pc_we     = (cur == S_WB);
   assign rf_we_en  = (cur == S_WB) && (op != OP_STORE) && (op != OP_BRANCH);
   assign trap      = (cur == S_TRAP);
   assign ban       = (cur == S_IDLE) || (cur == S_FETCH) || (cur == S_TRAP) || (cur == S_UNUSED);

endmodule

// File: tb/tb_cpu_sequencer.sv
// Self-checking bench for cpu_sequencer: per-instruction expected cycle traces compared every cycle.
module tb_cpu_sequencer;

   logic        clk = 1'b0, rst_n = 1'b0, run = 1'b0, imem_ack = 1'b0, dmem_ack = 1'b0;
   logic [4:0]  op = '0;
   logic [2:0]  func3 = '0;
   logic        imem_req, dmem_req, ir_we, pc_we, rf_we_en, mem_we_en, ban, trap;
   logic [2:0]  state;
   logic [31:0] retired;

   cpu_sequencer dut (
      .clk(clk), .rst_n(rst_n), .run(run), .imem_ack(imem_ack), .dmem_ack(dmem_ack),
      .op(op), .func3(func3), .imem_req(imem_req), .dmem_req(dmem_req), .ir_we(ir_we),
      .pc_we(pc_we), .rf_we_en(rf_we_en), .mem_we_en(mem_we_en), .ban(ban),
      .state(state), .trap(trap), .retired(retired)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [2:0]  st;
      logic        ireq, dreq, irwe, pcwe, rfwe, memwe, ban, trap;
      logic [31:0] ret;
   } exp_t;

   exp_t        q[$];
   logic [31:0] exp_retired = '0;
   int          n_checks = 0, n_fail = 0, busy_cycles = 0;

   logic [4:0] legal_ops [9] = '{5'b01101, 5'b00101, 5'b00100, 5'b01100, 5'b11011,
                                 5'b11001, 5'b11000, 5'b00000, 5'b01000};
   logic [7:0] bad_f3    [9] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h0C, 8'hC8, 8'hF8};

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   function automatic bit legal(input logic [4:0] o, input logic [2:0] f);
      for (int i = 0; i < 9; i++)
         if (legal_ops[i] == o) return !bad_f3[i][f];
      return 1'b0;
   endfunction

   // Expected outputs for a cycle spent in phase st, before per-phase strobes are added.
   function automatic exp_t mk(input logic [2:0] st);
      exp_t e;
      e      = '0;
      e.st   = st;
      e.ban  = (st == 3'd0 || st == 3'd1 || st == 3'd7);
      e.trap = (st == 3'd7);
      e.ret  = exp_retired;
      return e;
   endfunction

   task automatic cyc(input logic r, input logic ia, input logic da,
                      input logic [4:0] o, input logic [2:0] f, input exp_t e);
      @(posedge clk);
      #1;
      run = r; imem_ack = ia; dmem_ack = da; op = o; func3 = f;
      q.push_back(e);
   endtask

   function automatic logic rb();
      return logic'($urandom_range(0, 1));
   endfunction

   // Leaves the DUT in IDLE with run=1, so the next cycle is FETCH.
   task automatic do_reset();
      @(posedge clk);
      #1;
      rst_n = 1'b0; run = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0;
      exp_retired = '0;
      q.push_back(mk(3'd0));
      @(posedge clk);
      #1;
      rst_n = 1'b1; run = 1'b1;
      q.push_back(mk(3'd0));
   endtask

   task automatic trap_then_reset(input logic [4:0] o, input logic [2:0] f);
      repeat ($urandom_range(2, 4)) cyc(rb(), rb(), rb(), o, f, mk(3'd7));
      do_reset();
   endtask

   // One instruction starting in FETCH; always leaves the DUT about to enter FETCH.
   task automatic do_instr(input logic [4:0] o, input logic [2:0] f, input int fw, input int mw,
                           input logic run_after, input bit rst_in_mem);
      exp_t e;
      for (int i = 0; i <= fw; i++) begin
         e = mk(3'd1); e.ireq = 1'b1; e.irwe = (i == fw);
         cyc(rb(), i == fw, rb(), o, f, e);
      end
      cyc(rb(), rb(), rb(), o, f, mk(3'd2));
      if (!legal(o, f)) begin
         trap_then_reset(o, f);
         return;
      end
      cyc(rb(), rb(), rb(), o, f, mk(3'd3));
      if (o == 5'b00000 || o == 5'b01000) begin
         for (int i = 0; i <= mw; i++) begin
            e = mk(3'd4); e.dreq = 1'b1; e.memwe = (o == 5'b01000);
            cyc(rb(), rb(), i == mw, o, f, e);
            if (rst_in_mem && i == 1) begin
               do_reset();
               return;
            end
         end
      end
      e = mk(3'd5); e.pcwe = 1'b1; e.rfwe = !(o == 5'b01000 || o == 5'b11000);
      cyc(run_after, rb(), rb(), o, f, e);
      exp_retired++;
      if (!run_after) begin
         repeat ($urandom_range(0, 2)) cyc(1'b0, rb(), rb(), o, f, mk(3'd0));
         cyc(1'b1, rb(), rb(), o, f, mk(3'd0));
      end
   endtask

   // Single compare process: every cycle with an expectation is checked at the falling edge.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (state >= 3'd1 && state <= 3'd5) busy_cycles++;
         if (q.size() > 0) begin
            e = q.pop_front();
            check("state",     32'(state),     32'(e.st));
            check("imem_req",  32'(imem_req),  32'(e.ireq));
            check("dmem_req",  32'(dmem_req),  32'(e.dreq));
            check("ir_we",     32'(ir_we),     32'(e.irwe));
            check("pc_we",     32'(pc_we),     32'(e.pcwe));
            check("rf_we_en",  32'(rf_we_en),  32'(e.rfwe));
            check("mem_we_en", 32'(mem_we_en), 32'(e.memwe));
            check("ban",       32'(ban),       32'(e.ban));
            check("trap",      32'(trap),      32'(e.trap));
            check("retired",   retired,        e.ret);
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [4:0] o;
      logic [2:0] f;
      int fw, mw;
      bit rm;

      do_reset();
      // ADDI (4 cycles), LW with 3-cycle dmem delay (8 cycles), SW zero-wait (5 cycles).
      do_instr(5'b00100, 3'b000, 0, 0, 1'b1, 1'b0);
      do_instr(5'b00000, 3'b010, 0, 3, 1'b1, 1'b0);
      do_instr(5'b01000, 3'b010, 0, 0, 1'b0, 1'b0);
      @(negedge clk);
      #1;
      check("busy_cycles_literal", 32'(busy_cycles), 32'd17);
      check("retired_literal", retired, 32'd3);

      do_instr(5'b11000, 3'b000, 0, 0, 1'b1, 1'b0);
      do_instr(5'b11111, 3'b000, 0, 0, 1'b1, 1'b0);
      do_instr(5'b11000, 3'b010, 1, 0, 1'b1, 1'b0);
      do_instr(5'b00100, 3'b001, 0, 0, 1'b1, 1'b0);
      do_instr(5'b00000, 3'b010, 0, 3, 1'b1, 1'b1);

`ifdef SEQ_MEM_TIMEOUT_EN
      for (int i = 0; i < 16; i++) begin
         exp_t e;
         e = mk(3'd1); e.ireq = 1'b1;
         cyc(rb(), 1'b0, rb(), 5'b00100, 3'b000, e);
      end
      trap_then_reset(5'b00100, 3'b000);
      do_instr(5'b00100, 3'b000, 15, 0, 1'b1, 1'b0);
      do_instr(5'b00000, 3'b010, 0, 15, 1'b1, 1'b0);
`else
      do_instr(5'b00100, 3'b000, 100, 0, 1'b1, 1'b0);
`endif

      for (int n = 0; n < 250; n++) begin
         if ($urandom_range(0, 99) < 85) o = legal_ops[$urandom_range(0, 8)];
         else o = 5'($urandom);
         f  = 3'($urandom);
         fw = $urandom_range(0, 4);
         mw = $urandom_range(0, 4);
         rm = ($urandom_range(0, 19) == 0);
         if (rm && mw < 2) mw = 2;
         do_instr(o, f, fw, mw, rb(), rm);
      end

      @(negedge clk);
      #1;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
